// File: rtl/serial_to_parallel_aligner.sv
// Serial-to-parallel receive aligner.
// Shifts in a bit-serial stream MSB first, finds the byte boundary with a
// sliding compare against COM_SYMBOL, and locks after COM_COUNT consecutive
// boundary-aligned COMs. Once active, it presents every completed byte on
// data_out. valid_out flags non-COM bytes, and byte_strobe marks each
// completion edge. Only reset leaves the active state.
module serial_to_parallel_aligner #(
  parameter logic [7:0]  COM_SYMBOL = 8'hBC,
  parameter int unsigned COM_COUNT  = 4
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [3:0] COM_TARGET = 4'(COM_COUNT);

  state_t     state_q,       state_d;
  logic [7:0] shift_q,       shift_d;
  logic [2:0] bit_cnt_q,     bit_cnt_d;
  logic [3:0] com_cnt_q,     com_cnt_d;
  logic [7:0] data_out_q,    data_out_d;
  logic       valid_q,       valid_d;
  logic       strobe_q,      strobe_d;

  logic [7:0] nxt;
  logic       byte_done;
  logic       nxt_is_com;
  logic [3:0] com_inc;

  // Window including the bit sampled on this edge, and byte-boundary decode.
  always_comb begin
    nxt        = {shift_q[6:0], data_in};
    byte_done  = (bit_cnt_q == 3'd7);
    nxt_is_com = (nxt == COM_SYMBOL);
    com_inc    = com_cnt_q + 4'd1;
  end

  // Next-state and output computation for the alignment FSM.
  always_comb begin
    state_d    = state_q;
    shift_d    = nxt;
    bit_cnt_d  = bit_cnt_q;
    com_cnt_d  = com_cnt_q;
    data_out_d = data_out_q;
    valid_d    = valid_q;
    strobe_d   = 1'b0;

    unique case (state_q)
      SEARCH: begin
        // Bit-by-bit slide. A hit fixes the byte boundary at this edge.
        bit_cnt_d = 3'd0;
        if (nxt_is_com) begin
          com_cnt_d = 4'd1;
          state_d   = (COM_COUNT == 1) ? ACTIVE : ALIGN;
        end
      end

      ALIGN: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (byte_done) begin
          if (nxt_is_com) begin
            com_cnt_d = com_inc;
            if (com_inc == COM_TARGET) begin
              state_d = ACTIVE;
            end
          end else begin
            // Broken run: drop the boundary and resume sliding next edge.
            com_cnt_d = 4'd0;
            state_d   = SEARCH;
          end
        end
      end

      ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (byte_done) begin
          data_out_d = nxt;
          valid_d    = !nxt_is_com;
          strobe_d   = 1'b1;
        end
      end

      default: begin
        state_d   = SEARCH;
        bit_cnt_d = 3'd0;
        com_cnt_d = 4'd0;
      end
    endcase
  end

  // State and datapath registers. Reset asynchronously clears everything.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= SEARCH;
      shift_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      com_cnt_q  <= 4'd0;
      data_out_q <= 8'h00;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      com_cnt_q  <= com_cnt_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      strobe_q   <= strobe_d;
    end
  end

  // Drive the output ports from the registers.
  always_comb begin
    data_out    = data_out_q;
    valid_out   = valid_q;
    byte_strobe = strobe_q;
    active      = (state_q == ACTIVE);
  end

endmodule

// File: tb/tb_serial_to_parallel_aligner.sv
// Testbench for serial_to_parallel_aligner.
// A byte-level reference model tracks the recent bit history, the number
// of bits since the last boundary, and the lock mode. Every applied bit is
// compared against that model, and spot checks use literal expected values.
module tb_serial_to_parallel_aligner;

  localparam logic [7:0] COM = 8'hBC;
  localparam int         NCOM = 4;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  int vectors = 0;
  int errors  = 0;

  // Reference model state. mode: 0 hunting, 1 counting COMs, 2 locked.
  int         m_mode, m_hist, m_phase, m_coms;
  logic [7:0] m_data;
  logic       m_valid, m_strobe;

  serial_to_parallel_aligner #(.COM_SYMBOL(COM), .COM_COUNT(NCOM)) dut (
    .clk(clk), .reset_L(reset_L), .data_in(data_in),
    .data_out(data_out), .valid_out(valid_out),
    .byte_strobe(byte_strobe), .active(active)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_mode = 0; m_hist = 0; m_phase = 0; m_coms = 0;
    m_data = 8'h00; m_valid = 1'b0; m_strobe = 1'b0;
  endfunction

  function automatic void model_step(input logic b);
    int w;
    w = (m_hist * 2 + int'(b)) % 256;
    m_strobe = 1'b0;
    if (m_mode == 0) begin
      if (w == int'(COM)) begin
        m_phase = 0;
        m_coms  = 1;
        m_mode  = (NCOM == 1) ? 2 : 1;
      end
    end else begin
      m_phase = m_phase + 1;
      if (m_phase == 8) begin
        m_phase = 0;
        if (m_mode == 1) begin
          if (w == int'(COM)) begin
            m_coms = m_coms + 1;
            if (m_coms == NCOM) m_mode = 2;
          end else begin
            m_coms = 0;
            m_mode = 0;
          end
        end else begin
          m_data   = 8'(w);
          m_valid  = (w != int'(COM));
          m_strobe = 1'b1;
        end
      end
    end
    m_hist = w;
  endfunction

  // Apply one bit, let the edge sample it, then compare with the model.
  task automatic send_bit(input logic b, input string tag);
    logic [10:0] got, exp;
    data_in = b;
    @(posedge clk);
    #1;
    model_step(b);
    got = {active, valid_out, byte_strobe, data_out};
    exp = {(m_mode == 2), m_valid, m_strobe, m_data};
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got act/vld/stb/data=%b/%b/%b/%h expected %b/%b/%b/%h",
               tag, got[10], got[9], got[8], got[7:0],
               exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input string tag);
    for (int i = 7; i >= 0; i--) send_bit(v[i], tag);
  endtask

  task automatic check_outs(input logic [10:0] exp, input string tag);
    logic [10:0] got;
    got = {active, valid_out, byte_strobe, data_out};
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got act/vld/stb/data=%b/%b/%b/%h expected %b/%b/%b/%h",
               tag, got[10], got[9], got[8], got[7:0],
               exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic do_reset_pulse();
    #3 reset_L = 1'b0;
    #1 model_reset();
    check_outs(11'h000, "reset_async_clear");
    for (int i = 0; i < 3; i++) begin
      data_in = 1'($urandom);
      @(posedge clk);
      #1 check_outs(11'h000, "reset_held");
    end
    reset_L = 1'b1;
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      data_in = ~data_in;
      @(posedge clk);
      #1 check_outs(11'h000, "reset_toggle");
    end
    reset_L = 1'b1;
  endtask

  task automatic test_align_basic();
    for (int i = 0; i < 3; i++) send_bit(1'($urandom), "basic_junk");
    for (int i = 0; i < 3; i++) send_byte(COM, "basic_com");
    for (int i = 7; i >= 1; i--) send_bit(COM[i], "basic_com4");
    check_outs({1'b0, 1'b0, 1'b0, 8'h00}, "basic_before_lock");
    send_bit(COM[0], "basic_com4_last");
    check_outs({1'b1, 1'b0, 1'b0, 8'h00}, "basic_lock_edge");
    send_byte(8'hA5, "basic_a5");
    check_outs({1'b1, 1'b1, 1'b1, 8'hA5}, "basic_a5_strobe");
    send_bit(1'b0, "basic_3c");
    check_outs({1'b1, 1'b1, 1'b0, 8'hA5}, "basic_a5_hold");
    for (int i = 6; i >= 0; i--) send_bit(logic'((8'h3C >> i) & 8'h01), "basic_3c");
    check_outs({1'b1, 1'b1, 1'b1, 8'h3C}, "basic_3c_strobe");
  endtask

  task automatic test_misalign();
    do_reset_pulse();
    for (int i = 0; i < 3; i++) send_byte(COM, "mis_com");
    send_byte(8'h55, "mis_55");
    check_outs({1'b0, 1'b0, 1'b0, 8'h00}, "mis_back_to_search");
    for (int i = 0; i < 4; i++) send_byte(COM, "mis_realign");
    check_outs({1'b1, 1'b0, 1'b0, 8'h00}, "mis_relocked");
    send_byte(8'h11, "mis_11");
    check_outs({1'b1, 1'b1, 1'b1, 8'h11}, "mis_11_presented");
  endtask

  task automatic test_com_in_active();
    send_byte(8'h0F, "act_0f");
    check_outs({1'b1, 1'b1, 1'b1, 8'h0F}, "act_0f_out");
    send_byte(COM, "act_com");
    check_outs({1'b1, 1'b0, 1'b1, COM}, "act_com_skip");
    send_byte(8'hF0, "act_f0");
    check_outs({1'b1, 1'b1, 1'b1, 8'hF0}, "act_f0_out");
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int last = -1;
    int gap_bad = 0;
    for (int i = 0; i < 40; i++) begin
      send_bit(1'b1, "ff_stream");
      if (byte_strobe) begin
        if (last >= 0 && i - last != 8) gap_bad++;
        last = i;
        pulses++;
      end
    end
    vectors++;
    if (pulses !== 5 || gap_bad !== 0) begin
      errors++;
      $display("FAIL ff_strobe_count: got %0d pulses (%0d bad gaps) expected 5 (0)",
               pulses, gap_bad);
    end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] b1;
    b1 = 8'($urandom);
    send_byte(b1, "mid_byte1");
    for (int i = 7; i >= 5; i--) send_bit(1'($urandom), "mid_byte2_part");
    do_reset_pulse();
    for (int i = 0; i < 4; i++) send_byte(COM, "mid_realign");
    send_byte(8'hC3, "mid_c3");
    check_outs({1'b1, 1'b1, 1'b1, 8'hC3}, "mid_c3_presented");
  endtask

  task automatic test_random();
    do_reset_pulse();
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        send_byte(COM, "rand_com");
      end else if ($urandom_range(0, 3) == 0) begin
        for (int k = $urandom_range(1, 7); k > 0; k--) send_bit(1'($urandom), "rand_bits");
      end else begin
        send_byte(8'($urandom), "rand_byte");
      end
    end
  endtask

  initial begin
    test_reset();
    test_align_basic();
    test_misalign();
    test_com_in_active();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel_aligner.md
Name: serial_to_parallel_aligner

Overview:
- Receive-side deserializer that sits directly upstream of the 1x4 8-bit lane demultiplexer.
- Shifts in a serial bit stream and finds the byte boundary by locating the COM symbol.
- Declares the link active after a run of consecutive aligned COM symbols, then presents parallel bytes with a valid flag for the demux to consume.
- Runs on the single bit-rate clock of the receive path.

Parameters:
- COM_SYMBOL, 8'hBC, alignment/comma byte (K28.5 payload).
- COM_COUNT, 4, consecutive boundary-aligned COMs required to enter ACTIVE (range 1..15).

Ports:
- clk  input  1  bit-rate clock; all state changes on its rising edge.
- reset_L  input  1  asynchronous active-low reset.
- data_in  input  1  serial bit, MSB of each byte first.
- data_out  output  8  last completed byte, held until the next byte completes.
- valid_out  output  1  data_out holds a non-COM byte received while ACTIVE.
- byte_strobe  output  1  one-cycle pulse on each byte-completion edge in ACTIVE.
- active  output  1  alignment achieved (state == ACTIVE).

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (reset_L).
- Reset (reset_L=0, asynchronous) clears everything immediately: state=SEARCH, shift_reg=0, bit_cnt=0, com_cnt=0, data_out=8'h00, valid_out=0, byte_strobe=0, active=0.
- Reset asserted mid-operation discards any partial byte and alignment. After release, the search restarts from an empty shift register.
- Shifting: every edge, shift_reg <= {shift_reg[6:0], data_in}. Define nxt = {shift_reg[6:0], data_in}.
- bit_cnt is 3 bits and wraps 7 -> 0. A byte completes on the edge where bit_cnt==7, i.e. when its 8th bit is sampled.
- State SEARCH (bit-by-bit sliding compare):
  - If nxt==COM_SYMBOL: bit_cnt<=0, com_cnt<=1. If COM_COUNT==1, go to ACTIVE; otherwise go to ALIGN.
  - Otherwise stay in SEARCH; bit_cnt is unused.
- State ALIGN: bit_cnt increments each edge. On byte completion:
  - nxt==COM_SYMBOL: com_cnt<=com_cnt+1. If com_cnt+1==COM_COUNT, go to ACTIVE.
  - nxt!=COM_SYMBOL: go to SEARCH with com_cnt<=0. The compare against this byte is not reused; sliding resumes on the next edge.
- Outputs in SEARCH and ALIGN: valid_out=0, byte_strobe=0, active=0, data_out holds its value.
- Entering ACTIVE: active=1 from the edge that completes the COM_COUNT-th COM. That COM is not presented (valid_out stays 0).
- State ACTIVE: bit_cnt keeps wrapping. On each byte-completion edge:
  - data_out<=nxt.
  - valid_out<=(nxt!=COM_SYMBOL).
  - byte_strobe<=1 for exactly that cycle.
- Between completions in ACTIVE, data_out and valid_out hold their values for 8 clk cycles and byte_strobe=0.
- ACTIVE is left only by reset. A COM arriving in ACTIVE is a legal skip/idle byte (valid_out=0) and causes no re-alignment.
- Latency: data_out, valid_out and byte_strobe are registered outputs. They update on the same edge that samples the byte's last bit, so they are visible 1 clk after that bit is presented on data_in.
- Simultaneous events:
  - A COM completing on the same edge the count is reached enters ACTIVE; the next byte is the first one presented.
  - In SEARCH, a COM pattern straddling a partial stale shift_reg after reset cannot match, because shift_reg is zeroed on reset and 8'h00 != COM_SYMBOL.

Test Plan:
- Reset with data_in toggling -> data_out=8'h00, valid_out=0, byte_strobe=0, active=0 throughout; reset_L asserted mid-cycle clears outputs without waiting for an edge.
- 3 junk bits, then BC,BC,BC,BC,A5,3C MSB-first -> active rises on the edge sampling the last bit of the 4th BC. data_out=A5 with valid_out=1 and a 1-cycle byte_strobe 8 clks later, then data_out=3C 8 clks after that.
- BC,BC,BC,55,BC,BC,BC,BC,11 -> the 55 byte returns to SEARCH with active=0; realignment on the following four BCs; 11 presented with valid_out=1.
- ACTIVE, stream 0F,BC,F0 -> data_out=0F valid=1; data_out=BC valid=0 with strobe still pulsing; data_out=F0 valid=1; active stays 1.
- ACTIVE with 8'hFF data for 40 clks -> exactly 5 byte_strobe pulses spaced 8 clks apart, valid_out=1 continuously.
- Reset pulse during the 2nd data byte of ACTIVE, then BC x4 + C3 -> all outputs cleared immediately; alignment reacquired; C3 presented valid.
